// File: rtl/ysyx_25040129_axi_arbiter.sv
// Two-to-one AXI4 arbiter: IFU (m0, read-only) and LSU (m1, read/write) share one downstream port,
// one whole transaction in flight. Define YSYX_25040129_ARB_FIXED_PRIO_EN for strict m1 priority.
module ysyx_25040129_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic [7:0]            m0_arlen,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,

    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic [7:0]            m1_arlen,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    output logic [1:0]            m1_bresp,

    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic [7:0]            s_arlen,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    input  logic [1:0]            s_bresp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_M0 = 2'd1,
        RD_M1 = 2'd2,
        WR_M1 = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   req0_s;
    logic   req1_s;
    logic   pick_m1_s;
    logic   done_s;
`ifndef YSYX_25040129_ARB_FIXED_PRIO_EN
    logic   last_grant_r;
`endif

    // Request decode, tie-break and release detection
    always_comb begin
        req0_s       = m0_arvalid;
        req1_s       = m1_awvalid | m1_arvalid;
        next_state_s = state_r;
        done_s       = 1'b0;
        if (req0_s && req1_s) begin
`ifdef YSYX_25040129_ARB_FIXED_PRIO_EN
            pick_m1_s = 1'b1;
`else
            pick_m1_s = ~last_grant_r;
`endif
        end else begin
            pick_m1_s = req1_s;
        end
        case (state_r)
            IDLE: begin
                if (pick_m1_s) begin
                    if (m1_awvalid) begin
                        next_state_s = WR_M1;
                    end else begin
                        next_state_s = RD_M1;
                    end
                end else if (req0_s) begin
                    next_state_s = RD_M0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD_M0: begin
                done_s       = s_rvalid & m0_rready & s_rlast;
                next_state_s = done_s ? IDLE : RD_M0;
            end
            RD_M1: begin
                done_s       = s_rvalid & m1_rready & s_rlast;
                next_state_s = done_s ? IDLE : RD_M1;
            end
            WR_M1: begin
                done_s       = s_bvalid & m1_bready;
                next_state_s = done_s ? IDLE : WR_M1;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Grant state and round-robin history; a grant always passes through IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
`ifndef YSYX_25040129_ARB_FIXED_PRIO_EN
            last_grant_r <= 1'b1;
`endif
        end else begin
            state_r <= next_state_s;
`ifndef YSYX_25040129_ARB_FIXED_PRIO_EN
            if (done_s) begin
                last_grant_r <= (state_r != RD_M0);
            end else begin
                last_grant_r <= last_grant_r;
            end
`endif
        end
    end

    // Pass-through routing to the granted requester; everything else held at zero
    always_comb begin
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rlast   = 1'b0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rlast   = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bresp   = 2'b00;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_arlen    = 8'd0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_awaddr   = '0;
        s_wvalid   = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_bready   = 1'b0;
        case (state_r)
            RD_M0: begin
                s_arvalid  = m0_arvalid;
                s_araddr   = m0_araddr;
                s_arlen    = m0_arlen;
                m0_arready = s_arready;
                m0_rvalid  = s_rvalid;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rlast   = s_rlast;
                s_rready   = m0_rready;
            end
            RD_M1: begin
                s_arvalid  = m1_arvalid;
                s_araddr   = m1_araddr;
                s_arlen    = m1_arlen;
                m1_arready = s_arready;
                m1_rvalid  = s_rvalid;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rlast   = s_rlast;
                s_rready   = m1_rready;
            end
            WR_M1: begin
                s_awvalid  = m1_awvalid;
                s_awaddr   = m1_awaddr;
                m1_awready = s_awready;
                s_wvalid   = m1_wvalid;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                m1_wready  = s_wready;
                m1_bvalid  = s_bvalid;
                m1_bresp   = s_bresp;
                s_bready   = m1_bready;
            end
            default: begin
                s_arvalid  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_axi_arbiter.sv
// Randomised bench for ysyx_25040129_axi_arbiter: a behavioural downstream slave, requester tasks
// that check every beat/response, and a grant-order model derived from the arbitration rule.
`timescale 1ns/1ps
module tb_ysyx_25040129_axi_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        m0_arvalid = 1'b0, m0_rready = 1'b0;
    logic [31:0] m0_araddr = 32'h0;
    logic [7:0]  m0_arlen = 8'h0;
    logic        m0_arready, m0_rvalid, m0_rlast;
    logic [31:0] m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_arvalid = 1'b0, m1_rready = 1'b0, m1_awvalid = 1'b0, m1_wvalid = 1'b0, m1_bready = 1'b0;
    logic [31:0] m1_araddr = 32'h0, m1_awaddr = 32'h0, m1_wdata = 32'h0;
    logic [7:0]  m1_arlen = 8'h0;
    logic [3:0]  m1_wstrb = 4'h0;
    logic        m1_arready, m1_rvalid, m1_rlast, m1_awready, m1_wready, m1_bvalid;
    logic [31:0] m1_rdata;
    logic [1:0]  m1_rresp, m1_bresp;
    logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [7:0]  s_arlen;
    logic [3:0]  s_wstrb;
    logic        s_arready = 1'b0, s_rvalid = 1'b0, s_rlast = 1'b0, s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  stall_en = 1'b0;
    bit  exp_last = 1'b1;
    int  grant_q[$];
    int  exp_q[$];
    int  cyc = 0;
    int  last_b_cyc = 0;
    int  ar_after_b = -1;

    always #5 clock = ~clock;

    ysyx_25040129_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
    );

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr, input int beat);
        return {addr[15:0], 16'h0000} + 32'(beat + 1) * 32'h11;
    endfunction

    function automatic bit rnd_ok();
        return stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    function automatic string order_str(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d", q[i])};
        return s;
    endfunction

    // Expected grant order when m0 has n0 back-to-back reads and m1 the listed kinds (1 read, 2 write)
    task automatic model_order(input int n0, input int k1[$]);
        int r0 = n0;
        int i1 = 0;
        bit pick1;
        exp_q.delete();
        while (r0 > 0 || i1 < k1.size()) begin
            if (r0 > 0 && i1 < k1.size()) begin
`ifdef YSYX_25040129_ARB_FIXED_PRIO_EN
                pick1 = 1'b1;
`else
                pick1 = ~exp_last;
`endif
            end else begin
                pick1 = (i1 < k1.size());
            end
            if (pick1) begin
                exp_q.push_back(k1[i1]);
                i1++;
                exp_last = 1'b1;
            end else begin
                exp_q.push_back(0);
                r0--;
                exp_last = 1'b0;
            end
        end
    endtask

    // Downstream slave: samples handshakes at negedge, updates its outputs just after posedge
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [31:0] ar_a, aw_a, w_d;
    logic [7:0]  ar_l;
    logic [3:0]  w_s;
    bit          rd_act = 1'b0, wr_aw = 1'b0, wr_w = 1'b0;
    logic [31:0] rd_addr = 32'h0, sl_awaddr = 32'h0, sl_wdata = 32'h0;
    logic [7:0]  rd_len = 8'h0;
    logic [3:0]  sl_wstrb = 4'h0;
    int          rd_beat = 0;
    always begin
        @(negedge clock);
        ar_hs = s_arvalid && s_arready;  ar_a = s_araddr;  ar_l = s_arlen;
        r_hs  = s_rvalid && s_rready;
        aw_hs = s_awvalid && s_awready;  aw_a = s_awaddr;
        w_hs  = s_wvalid && s_wready;    w_d = s_wdata;    w_s = s_wstrb;
        b_hs  = s_bvalid && s_bready;
        @(posedge clock);
        #1;
        if (!reset) begin
            rd_act = 1'b0; wr_aw = 1'b0; wr_w = 1'b0;
            s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
            s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
        end else begin
            if (ar_hs) begin rd_act = 1'b1; rd_addr = ar_a; rd_len = ar_l; rd_beat = 0; end
            if (r_hs) begin
                if (rd_beat == int'(rd_len)) rd_act = 1'b0;
                else rd_beat++;
            end
            if (aw_hs) begin wr_aw = 1'b1; sl_awaddr = aw_a; end
            if (w_hs) begin wr_w = 1'b1; sl_wdata = w_d; sl_wstrb = w_s; end
            if (b_hs) begin wr_aw = 1'b0; wr_w = 1'b0; end
            s_arready = !rd_act && rnd_ok();
            if (!s_rvalid || r_hs) s_rvalid = rd_act && rnd_ok();
            s_rdata = exp_rdata(rd_addr, rd_beat);
            s_rresp = rd_addr[3:2];
            s_rlast = (rd_beat == int'(rd_len));
            s_awready = !wr_aw && rnd_ok();
            s_wready  = !wr_w && rnd_ok();
            if (!s_bvalid || b_hs) s_bvalid = wr_aw && wr_w && !b_hs && rnd_ok();
            s_bresp = sl_awaddr[3:2];
        end
    end

    // Protocol monitor: reset quiescence, single granted requester, idle read/write channel isolation
    always @(negedge clock) begin
        cyc++;
        n_checks++;
        if (!reset) begin
            if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m0_arready, m0_rvalid,
                 m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid} !== 12'h000) begin
                n_errors++;
                $display("FAIL reset_quiet: valid/ready outputs active during reset at cycle %0d, required all 0", cyc);
            end
        end else begin
            if ((m0_arready | m0_rvalid) && (m1_arready | m1_rvalid | m1_awready | m1_wready | m1_bvalid)) begin
                n_errors++;
                $display("FAIL exclusive_grant: both requesters see handshakes at cycle %0d, required one side only", cyc);
            end
            n_checks++;
            if (s_arvalid && (s_awvalid || s_wvalid)) begin
                n_errors++;
                $display("FAIL channel_isolation: s_arvalid with s_awvalid/s_wvalid at cycle %0d, required exclusive", cyc);
            end
            if (s_bvalid && s_bready) begin
                last_b_cyc = cyc;
                ar_after_b = -1;
            end else if (s_arvalid && ar_after_b < 0) begin
                ar_after_b = cyc;
            end
        end
    end

    // Requester read: called just after a posedge, returns just after the releasing posedge
    task automatic do_read(input bit who, input logic [31:0] addr, input logic [7:0] len);
        bit ar_pend = 1'b1;
        bit done = 1'b0;
        bit hs_ar, hs_r;
        int beat = 0;
        int guard = 0;
        logic [31:0] rd;
        logic [1:0]  rr;
        logic        rl;
        if (who) begin m1_arvalid = 1'b1; m1_araddr = addr; m1_arlen = len; m1_rready = rnd_ok(); end
        else     begin m0_arvalid = 1'b1; m0_araddr = addr; m0_arlen = len; m0_rready = rnd_ok(); end
        while (!done && guard < 3000) begin
            @(negedge clock);
            if (who) begin
                hs_ar = m1_arvalid && m1_arready; hs_r = m1_rvalid && m1_rready;
                rd = m1_rdata; rr = m1_rresp; rl = m1_rlast;
            end else begin
                hs_ar = m0_arvalid && m0_arready; hs_r = m0_rvalid && m0_rready;
                rd = m0_rdata; rr = m0_rresp; rl = m0_rlast;
            end
            if (hs_ar && ar_pend) begin
                ar_pend = 1'b0;
                grant_q.push_back(who ? 1 : 0);
            end
            if (hs_r) begin
                n_checks++;
                if (rd !== exp_rdata(addr, beat) || rr !== addr[3:2] || rl !== (beat == int'(len))) begin
                    n_errors++;
                    $display("FAIL read_beat m%0d beat %0d: got data=%h resp=%0d last=%b, required data=%h resp=%0d last=%b",
                             who, beat, rd, rr, rl, exp_rdata(addr, beat), addr[3:2], (beat == int'(len)));
                end
                beat++;
                done = (beat > int'(len));
            end
            @(posedge clock);
            #1;
            guard++;
            if (who) begin m1_arvalid = ar_pend; m1_rready = rnd_ok(); end
            else     begin m0_arvalid = ar_pend; m0_rready = rnd_ok(); end
        end
        if (who) begin m1_arvalid = 1'b0; m1_rready = 1'b0; end
        else     begin m0_arvalid = 1'b0; m0_rready = 1'b0; end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL read_timeout m%0d: got %0d beats, required %0d", who, beat, int'(len) + 1);
        end
    endtask

    // LSU single write with independent aw/w valids
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_pend = 1'b1, w_pend = 1'b1, done = 1'b0;
        int guard = 0;
        m1_awvalid = 1'b1; m1_awaddr = addr;
        m1_wvalid = 1'b1;  m1_wdata = data; m1_wstrb = strb;
        m1_bready = rnd_ok();
        while (!done && guard < 3000) begin
            @(negedge clock);
            if (m1_awvalid && m1_awready && aw_pend) begin aw_pend = 1'b0; grant_q.push_back(2); end
            if (m1_wvalid && m1_wready) w_pend = 1'b0;
            if (m1_bvalid && m1_bready) begin
                done = 1'b1;
                n_checks++;
                if (m1_bresp !== addr[3:2] || sl_awaddr !== addr || sl_wdata !== data || sl_wstrb !== strb) begin
                    n_errors++;
                    $display("FAIL write_resp: got bresp=%0d aw=%h w=%h strb=%h, required bresp=%0d aw=%h w=%h strb=%h",
                             m1_bresp, sl_awaddr, sl_wdata, sl_wstrb, addr[3:2], addr, data, strb);
                end
            end
            @(posedge clock);
            #1;
            guard++;
            m1_awvalid = aw_pend; m1_wvalid = w_pend; m1_bready = rnd_ok();
        end
        m1_awvalid = 1'b0; m1_wvalid = 1'b0; m1_bready = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL write_timeout: got no b handshake, required one");
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_last = 1'b1;
    endtask

    task automatic test_reset();
        m0_arvalid = 1'b1; m0_araddr = 32'h3000_0000; m0_arlen = 8'd3;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (s_arvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_idle: got s_arvalid=%b, required 0", s_arvalid);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h3000_0000 || s_arlen !== 8'd3) begin
            n_errors++;
            $display("FAIL first_grant: got arvalid=%b addr=%h len=%0d, required 1 30000000 3", s_arvalid, s_araddr, s_arlen);
        end
        grant_q.delete();
        do_read(1'b0, 32'h3000_0000, 8'd3);
        exp_last = 1'b0;
    endtask

    task automatic test_m0_burst();
        stall_en = 1'b0;
        grant_q.delete();
        do_read(1'b0, 32'h3000_0000, 8'd3);
        exp_last = 1'b0;
        m0_rready = 1'b1;
        #1;
        n_checks++;
        if (s_rready !== 1'b0 || m0_rvalid !== 1'b0 || order_str(grant_q) != "0") begin
            n_errors++;
            $display("FAIL burst_release: got s_rready=%b order=%s, required 0 and order 0", s_rready, order_str(grant_q));
        end
        m0_rready = 1'b0;
    endtask

    task automatic test_round_robin();
        int k1[$];
        stall_en = 1'b1;
        pulse_reset();
        grant_q.delete();
        k1 = '{1, 1, 1};
        model_order(3, k1);
        fork
            for (int i = 0; i < 3; i++) do_read(1'b0, 32'h3000_0000 + 32'(i * 16), 8'($urandom_range(0, 3)));
            for (int j = 0; j < 3; j++) do_read(1'b1, 32'ha000_0000 + 32'(j * 4), 8'($urandom_range(0, 3)));
        join
        n_checks++;
        if (order_str(grant_q) != order_str(exp_q)) begin
            n_errors++;
            $display("FAIL rr_order: got %s, required %s", order_str(grant_q), order_str(exp_q));
        end
    endtask

    task automatic test_write_then_m0();
        int k1[$];
        stall_en = 1'b1;
        grant_q.delete();
        fork
            do_write(32'ha000_0010, 32'hdead_beef, 4'hf);
            begin
                @(posedge clock);
                #1;
                do_read(1'b0, 32'h3000_0040, 8'd1);
            end
        join
        exp_last = 1'b0;
        n_checks++;
        if (order_str(grant_q) != "20" || ar_after_b - last_b_cyc != 2) begin
            n_errors++;
            $display("FAIL write_then_m0: got order=%s gap=%0d, required order=20 gap=2", order_str(grant_q), ar_after_b - last_b_cyc);
        end
    endtask

    task automatic test_write_priority();
        stall_en = 1'b1;
        grant_q.delete();
        fork
            do_write($urandom, $urandom, 4'($urandom_range(0, 15)));
            do_read(1'b1, $urandom, 8'($urandom_range(0, 5)));
        join
        exp_last = 1'b1;
        n_checks++;
        if (order_str(grant_q) != "21") begin
            n_errors++;
            $display("FAIL m1_write_first: got order=%s, required 21", order_str(grant_q));
        end
    endtask

    task automatic test_burst_bounds();
        int k1[$];
        stall_en = 1'b1;
        grant_q.delete();
        do_read(1'b1, $urandom, 8'd0);
        do_read(1'b0, $urandom, 8'd255);
        exp_last = 1'b0;
        n_checks++;
        if (order_str(grant_q) != "10") begin
            n_errors++;
            $display("FAIL burst_bounds: got order=%s, required 10", order_str(grant_q));
        end
    endtask

    task automatic test_random();
        int kind;
        int k1[$];
        bit use0;
        logic [31:0] a0, a1;
        for (int r = 0; r < 14; r++) begin
            kind = int'($urandom_range(0, 4));
            use0 = (kind == 0 || kind == 3 || kind == 4);
            k1.delete();
            if (kind == 1 || kind == 3) k1.push_back(1);
            if (kind == 2 || kind == 4) k1.push_back(2);
            a0 = $urandom; a1 = $urandom;
            model_order(use0 ? 1 : 0, k1);
            grant_q.delete();
            fork
                begin if (use0) do_read(1'b0, a0, 8'($urandom_range(0, 7))); end
                begin
                    if (k1.size() != 0 && k1[0] == 1) do_read(1'b1, a1, 8'($urandom_range(0, 7)));
                    else if (k1.size() != 0) do_write(a1, $urandom, 4'($urandom_range(0, 15)));
                end
            join
            n_checks++;
            if (order_str(grant_q) != order_str(exp_q)) begin
                n_errors++;
                $display("FAIL random_order round %0d kind %0d: got %s, required %s", r, kind, order_str(grant_q), order_str(exp_q));
            end
        end
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        int guard = 0;
        bit arhs;
        stall_en = 1'b0;
        m0_araddr = 32'h3000_0000; m0_arlen = 8'd3; m0_arvalid = 1'b1; m0_rready = 1'b1;
        while (beats < 2 && guard < 100) begin
            @(negedge clock);
            arhs = m0_arvalid && m0_arready;
            if (m0_rvalid && m0_rready) beats++;
            @(posedge clock);
            #1;
            if (arhs) m0_arvalid = 1'b0;
            guard++;
        end
        #1;
        m0_arvalid = 1'b1;
        #1;
        n_checks++;
        if (s_rready !== 1'b1 || m0_rvalid !== 1'b1 || s_arvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_burst_active: got s_rready=%b m0_rvalid=%b s_arvalid=%b, required 1 1 1", s_rready, m0_rvalid, s_arvalid);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (s_rready !== 1'b0 || m0_rvalid !== 1'b0 || s_arvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got s_rready=%b m0_rvalid=%b s_arvalid=%b, required 0 0 0", s_rready, m0_rvalid, s_arvalid);
        end
        m0_arvalid = 1'b0; m0_rready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_last = 1'b1;
        grant_q.delete();
        do_read(1'b1, 32'ha000_0000, 8'd2);
        n_checks++;
        if (order_str(grant_q) != "1") begin
            n_errors++;
            $display("FAIL after_reset_read: got order=%s, required 1", order_str(grant_q));
        end
    endtask

    initial begin
        test_reset();
        test_m0_burst();
        test_round_robin();
        test_write_then_m0();
        test_write_priority();
        test_burst_bounds();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
